// File: rtl/pixel_stream_tx.sv
// Raster pixel source: reads one WIDTH x DEPTH frame from a synchronous-read
// memory in row-major order and presents it on a start/data_en/per_img_Y
// stream. FLUSH trailing zero pixels drain the downstream line buffers.
module pixel_stream_tx #(
  parameter int WIDTH      = 640,
  parameter int DEPTH      = 508,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 19,
  parameter int FLUSH      = 2,
  parameter int LINE_GAP   = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  frame_go,
  input  logic                  hold,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  start,
  output logic                  data_en,
  output logic [DATA_WIDTH-1:0] per_img_Y,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int XW = (WIDTH > 1)    ? $clog2(WIDTH)    : 1;
  localparam int YW = (DEPTH > 1)    ? $clog2(DEPTH)    : 1;
  localparam int GW = (LINE_GAP > 1) ? $clog2(LINE_GAP) : 1;
  localparam int FW = (FLUSH > 1)    ? $clog2(FLUSH)    : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_GAP,
    S_FLUSH,
    S_DRAIN
  } state_t;

  state_t state_q, state_d;

  logic [XW-1:0]         x_q;
  logic [YW-1:0]         y_q;
  logic [GW-1:0]         gap_cnt_q;
  logic [FW-1:0]         flush_cnt_q;
  logic [ADDR_WIDTH-1:0] addr_q;

  logic issue_rd, issue_flush;
  logic last_x, last_y, last_gap, last_flush;

  // Stage 1 tracks what was issued last cycle (real read or flush zero).
  logic v1_q, f1_q;
  logic data_en_q;

  assign last_x     = (x_q == XW'(WIDTH - 1));
  assign last_y     = (y_q == YW'(DEPTH - 1));
  assign last_gap   = (gap_cnt_q == GW'(LINE_GAP - 1));
  assign last_flush = (flush_cnt_q == FW'(FLUSH - 1));

  // The read strobe is decoded straight from state and hold so a stall
  // blocks the very cycle hold is raised; the address itself is a register.
  assign rd_en   = issue_rd;
  assign rd_addr = addr_q;
  assign start   = data_en_q;
  assign data_en = data_en_q;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode and issue strobes.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned and no latch is inferred.
    state_d     = state_q;
    issue_rd    = 1'b0;
    issue_flush = 1'b0;
    unique case (state_q)
      S_IDLE: if (frame_go) state_d = S_FETCH;
      S_FETCH: begin
        if (!hold) begin
          issue_rd = 1'b1;
          if (last_x) begin
            if (last_y)            state_d = (FLUSH > 0) ? S_FLUSH : S_DRAIN;
            else if (LINE_GAP > 0) state_d = S_GAP;
          end
        end
      end
      S_GAP: if (last_gap) state_d = S_FETCH;
      S_FLUSH: begin
        if (!hold) begin
          issue_flush = 1'b1;
          if (last_flush) state_d = S_DRAIN;
        end
      end
      S_DRAIN: if (!v1_q) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Raster position, linear address, gap and flush counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_q         <= '0;
      y_q         <= '0;
      gap_cnt_q   <= '0;
      flush_cnt_q <= '0;
      addr_q      <= '0;
    end else if (state_d == S_IDLE) begin
      x_q         <= '0;
      y_q         <= '0;
      gap_cnt_q   <= '0;
      flush_cnt_q <= '0;
      addr_q      <= '0;
    end else begin
      if (issue_rd) begin
        if (last_x) begin
          x_q <= '0;
          if (!last_y) y_q <= y_q + YW'(1);
        end else begin
          x_q <= x_q + XW'(1);
        end
        // The final address is held through flush and drain.
        if (!(last_x && last_y)) addr_q <= addr_q + ADDR_WIDTH'(1);
      end
      gap_cnt_q <= (state_q == S_GAP && !last_gap) ? gap_cnt_q + GW'(1) : '0;
      if (issue_flush && !last_flush) flush_cnt_q <= flush_cnt_q + FW'(1);
    end
  end

  // Two-stage output pipeline, frame_done and busy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_q       <= 1'b0;
      f1_q       <= 1'b0;
      data_en_q  <= 1'b0;
      per_img_Y  <= '0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      v1_q       <= issue_rd | issue_flush;
      f1_q       <= issue_flush;
      data_en_q  <= v1_q;
      if (v1_q) per_img_Y <= f1_q ? '0 : rd_data;
      // Drain is empty once stage 1 is idle; the last pixel is on the
      // output this cycle, so the pulse lands the cycle after it.
      frame_done <= (state_q == S_DRAIN) && !v1_q;
      if (state_q == S_IDLE && frame_go) busy <= 1'b1;
      else if (frame_done)               busy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pixel_stream_tx.sv
// Directed bench for pixel_stream_tx: three small instances (no line gap,
// gap of 3, and a no-flush/gap-1 variant) with a mem[i]=i+1 memory each.
module tb_pixel_stream_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hold;
  logic        go       [3];
  logic        rd_en    [3];
  logic [3:0]  rd_addr  [3];
  logic [15:0] rd_data  [3];
  logic        start    [3];
  logic        data_en  [3];
  logic [15:0] pix      [3];
  logic        busy     [3];
  logic        done     [3];

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int se_err = 0;

  int rd_addr_log [3][$];
  int rd_cyc_log  [3][$];
  int out_val_log [3][$];
  int out_cyc_log [3][$];
  int done_cyc_log[3][$];
  int busy_at_done[3];

  always #5 clk = ~clk;

  pixel_stream_tx #(.WIDTH(4), .DEPTH(3), .DATA_WIDTH(16), .ADDR_WIDTH(4),
                    .FLUSH(2), .LINE_GAP(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .frame_go(go[0]), .hold(hold),
    .rd_en(rd_en[0]), .rd_addr(rd_addr[0]), .rd_data(rd_data[0]),
    .start(start[0]), .data_en(data_en[0]), .per_img_Y(pix[0]),
    .busy(busy[0]), .frame_done(done[0]));

  pixel_stream_tx #(.WIDTH(4), .DEPTH(3), .DATA_WIDTH(16), .ADDR_WIDTH(4),
                    .FLUSH(2), .LINE_GAP(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .frame_go(go[1]), .hold(hold),
    .rd_en(rd_en[1]), .rd_addr(rd_addr[1]), .rd_data(rd_data[1]),
    .start(start[1]), .data_en(data_en[1]), .per_img_Y(pix[1]),
    .busy(busy[1]), .frame_done(done[1]));

  pixel_stream_tx #(.WIDTH(5), .DEPTH(3), .DATA_WIDTH(16), .ADDR_WIDTH(4),
                    .FLUSH(0), .LINE_GAP(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .frame_go(go[2]), .hold(hold),
    .rd_en(rd_en[2]), .rd_addr(rd_addr[2]), .rd_data(rd_data[2]),
    .start(start[2]), .data_en(data_en[2]), .per_img_Y(pix[2]),
    .busy(busy[2]), .frame_done(done[2]));

  // Synchronous-read memories holding mem[i] = i + 1.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++)
      if (rd_en[k]) rd_data[k] <= 16'(rd_addr[k]) + 16'd1;
  end

  // Monitor on the falling edge, away from the active edge.
  always @(negedge clk) begin
    cyc++;
    for (int k = 0; k < 3; k++) begin
      if (rd_en[k]) begin
        rd_addr_log[k].push_back(int'(rd_addr[k]));
        rd_cyc_log[k].push_back(cyc);
      end
      if (data_en[k]) begin
        out_val_log[k].push_back(int'(pix[k]));
        out_cyc_log[k].push_back(cyc);
      end
      if (done[k]) begin
        done_cyc_log[k].push_back(cyc);
        busy_at_done[k] = int'(busy[k]);
      end
      if (start[k] !== data_en[k]) se_err++;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_logs(input int k);
    rd_addr_log[k].delete();
    rd_cyc_log[k].delete();
    out_val_log[k].delete();
    out_cyc_log[k].delete();
    done_cyc_log[k].delete();
    busy_at_done[k] = 0;
  endtask

  task automatic pulse_go(input int k);
    @(posedge clk); #1 go[k] = 1'b1;
    @(posedge clk); #1 go[k] = 1'b0;
  endtask

  // Returns at the rising edge that ends the frame_done cycle.
  task automatic wait_done(input int k, input string nm);
    for (int n = 0; n < 400 && done_cyc_log[k].size() == 0; n++) @(posedge clk);
    check({nm, ":done_seen"}, int'(done_cyc_log[k].size() > 0), 1);
  endtask

  // Returns at the falling edge of the cycle that issues address a.
  task automatic wait_addr(input int k, input int a, input string nm);
    bit found = 1'b0;
    for (int n = 0; n < 200 && !found; n++) begin
      @(negedge clk);
      if (rd_en[k] && int'(rd_addr[k]) == a) found = 1'b1;
    end
    check({nm, ":addr_seen"}, int'(found), 1);
  endtask

  task automatic check_frame(input int k, input string nm, input int w, input int d,
                             input int f, input int gap, input int hold_after,
                             input int hold_len);
    int n = w * d;
    int bad;
    int idle;
    int expc;
    check({nm, ":rd_count"}, rd_addr_log[k].size(), n);
    bad = 0;
    foreach (rd_addr_log[k][i]) if (rd_addr_log[k][i] != i) bad++;
    check({nm, ":rd_order"}, bad, 0);
    bad = 0;
    for (int i = 1; i < rd_cyc_log[k].size(); i++) begin
      int a = rd_addr_log[k][i-1];
      if (a == hold_after)                   idle = hold_len;
      else if (gap > 0 && (a % w) == w - 1)  idle = gap;
      else                                   idle = 0;
      if (rd_cyc_log[k][i] - rd_cyc_log[k][i-1] - 1 != idle) bad++;
    end
    check({nm, ":rd_idle"}, bad, 0);
    check({nm, ":den_count"}, out_val_log[k].size(), n + f);
    bad = 0;
    foreach (out_val_log[k][i]) if (out_val_log[k][i] != ((i < n) ? i + 1 : 0)) bad++;
    check({nm, ":values"}, bad, 0);
    bad = 0;
    if (rd_cyc_log[k].size() != n || out_cyc_log[k].size() != n + f) bad = -1;
    else
      foreach (out_cyc_log[k][i]) begin
        expc = (i < n) ? rd_cyc_log[k][i] + 2 : rd_cyc_log[k][n-1] + 2 + (i - n + 1);
        if (out_cyc_log[k][i] != expc) bad++;
      end
    check({nm, ":latency"}, bad, 0);
    check({nm, ":done_count"}, done_cyc_log[k].size(), 1);
    if (done_cyc_log[k].size() > 0 && out_cyc_log[k].size() > 0)
      check({nm, ":done_time"}, done_cyc_log[k][0], out_cyc_log[k][$] + 1);
    check({nm, ":busy_at_done"}, busy_at_done[k], 1);
  endtask

  initial begin
    rst_n = 1'b0;
    hold  = 1'b0;
    for (int k = 0; k < 3; k++) go[k] = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst:rd_en",   int'(rd_en[0]),   0);
    check("rst:rd_addr", int'(rd_addr[0]), 0);
    check("rst:data_en", int'(data_en[0]), 0);
    check("rst:start",   int'(start[0]),   0);
    check("rst:pix",     int'(pix[0]),     0);
    check("rst:busy",    int'(busy[0]),    0);
    check("rst:done",    int'(done[0]),    0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Basic frame, no gap.
    clear_logs(0);
    pulse_go(0);
    wait_done(0, "t1");
    check_frame(0, "t1", 4, 3, 2, 0, -1, 0);
    @(negedge clk);
    check("t1:busy_after", int'(busy[0]), 0);
    check("t1:idle_addr",  int'(rd_addr[0]), 0);

    // Inter-line gap of 3.
    clear_logs(1);
    pulse_go(1);
    wait_done(1, "t2");
    check_frame(1, "t2", 4, 3, 2, 3, -1, 0);

    // Stall for 4 cycles right after address 4 is issued.
    clear_logs(0);
    pulse_go(0);
    wait_addr(0, 4, "t3");
    @(posedge clk); #1 hold = 1'b1;
    repeat (4) @(posedge clk);
    #1 hold = 1'b0;
    wait_done(0, "t3");
    check_frame(0, "t3", 4, 3, 2, 0, 4, 4);

    // frame_go while busy is ignored; frame_go right after done restarts.
    clear_logs(0);
    pulse_go(0);
    repeat (3) @(posedge clk);
    #1 go[0] = 1'b1;
    @(posedge clk); #1 go[0] = 1'b0;
    wait_done(0, "t4a");
    check_frame(0, "t4a", 4, 3, 2, 0, -1, 0);
    clear_logs(0);
    #1 go[0] = 1'b1;
    @(posedge clk); #1 go[0] = 1'b0;
    wait_done(0, "t4b");
    check_frame(0, "t4b", 4, 3, 2, 0, -1, 0);

    // One-cycle reset while address 6 is on the bus.
    clear_logs(0);
    pulse_go(0);
    wait_addr(0, 6, "t5");
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("t5:rd_en",   int'(rd_en[0]),   0);
    check("t5:start",   int'(start[0]),   0);
    check("t5:data_en", int'(data_en[0]), 0);
    check("t5:busy",    int'(busy[0]),    0);
    check("t5:done",    int'(done[0]),    0);
    check("t5:pix",     int'(pix[0]),     0);
    repeat (10) @(posedge clk);
    check("t5:no_done", done_cyc_log[0].size(), 0);
    clear_logs(0);
    pulse_go(0);
    wait_done(0, "t5r");
    check_frame(0, "t5r", 4, 3, 2, 0, -1, 0);

    // No flush, gap of 1, frame_go accepted together with hold.
    clear_logs(2);
    @(posedge clk); #1 hold = 1'b1; go[2] = 1'b1;
    @(posedge clk); #1 go[2] = 1'b0;
    repeat (2) @(posedge clk);
    check("t6:no_read_in_hold", rd_addr_log[2].size(), 0);
    #1 hold = 1'b0;
    wait_done(2, "t6");
    check_frame(2, "t6", 5, 3, 0, 1, -1, 0);

    check("start_eq_data_en", se_err, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pixel_stream_tx.md
Name: pixel_stream_tx

Overview:
- Raster pixel source for the Canny pipeline. On request, it reads one WIDTH x DEPTH frame from a synchronous-read frame memory in row-major order.
- It drives the pixel-stream interface used by the 3x3 window / threshold stages: start, data_en and per_img_Y.
- After the frame it appends FLUSH zero pixels so the downstream line buffers drain their final window.
- It supports stalling via hold, optional inter-line blanking, and a frame-done pulse.

Parameters:
WIDTH, 640, pixels per line
DEPTH, 508, lines per frame
DATA_WIDTH, 16, pixel width
ADDR_WIDTH, 19, memory address width; must satisfy 2^ADDR_WIDTH >= WIDTH*DEPTH
FLUSH, 2, number of trailing zero pixels after the last real pixel (0 allowed)
LINE_GAP, 0, idle cycles inserted after each line except the last

Ports:
clk  in  1  system clock, all logic rising-edge
rst_n  in  1  reset; synchronous, active-low
frame_go  in  1  request one frame; sampled only in IDLE
hold  in  1  when 1, no new memory read is issued
rd_en  out  1  memory read strobe
rd_addr  out  ADDR_WIDTH  memory read address, linear row-major (y*WIDTH+x)
rd_data  in  DATA_WIDTH  memory data, valid the cycle after rd_en
start  out  1  pixel-stream shift enable to downstream
data_en  out  1  pixel valid; identical timing to start
per_img_Y  out  DATA_WIDTH  pixel value
busy  out  1  frame in progress
frame_done  out  1  one-cycle pulse at end of frame

Behaviour:
- Reset (rst_n=0 at a clock edge): all outputs are 0, the FSM goes to IDLE and all counters clear.
  - Reset mid-frame drops in-flight pixels; no frame_done is generated.
- FSM states: IDLE, FETCH, GAP, FLUSH, DRAIN.
  - IDLE -> FETCH on frame_go=1. frame_go while not in IDLE is ignored.
  - FETCH: each cycle with hold=0, assert rd_en with rd_addr = current address, then increment x.
    - At x=WIDTH-1 with y<DEPTH-1: x<=0, y<=y+1, go to GAP if LINE_GAP>0.
    - At the last pixel (x=WIDTH-1, y=DEPTH-1): go to FLUSH if FLUSH>0, else DRAIN.
  - GAP: count LINE_GAP cycles, hold-independent, no reads; then return to FETCH.
  - FLUSH: each cycle with hold=0, inject one zero pixel into the pipeline (no rd_en). After FLUSH injections, go to DRAIN.
  - DRAIN: wait until the pipeline is empty, assert frame_done for 1 cycle, then go to IDLE.
- Pipeline latency: rd_en in cycle N -> rd_data in N+1 -> start=data_en=1 with per_img_Y=rd_data in cycle N+2, all outputs registered. Flush pixels follow the same 2-cycle latency with value 0.
- hold only blocks issue. Pixels already issued (at most 2) still emerge; the stream resumes with the next address and no pixel is skipped or duplicated.
- start and data_en are always equal. per_img_Y holds its last value while data_en=0.
- rd_addr is 0 in IDLE and restarts at 0 for every frame. It holds its value while rd_en=0.
- busy=1 from the cycle after frame_go is accepted through the cycle frame_done=1, inclusive. frame_done is asserted in the cycle after the last data_en. A frame_go in the following cycle (IDLE) is accepted.
- frame_go and hold together in IDLE: the frame is accepted and reads begin when hold drops.
- Per frame, data_en is high for exactly WIDTH*DEPTH+FLUSH cycles. Counters x, y and the gap/flush counters are sized by $clog2 and never wrap outside their ranges.

Test Plan:
1. WIDTH=4, DEPTH=3, FLUSH=2, LINE_GAP=0, mem[i]=i+1, frame_go pulse:
   - rd_addr runs 0..11 over 12 consecutive rd_en cycles.
   - data_en is high for 14 consecutive cycles, starting 2 cycles after the first rd_en.
   - per_img_Y = 1..12, 0, 0.
   - frame_done pulses 1 cycle after the last data_en.
2. Same with LINE_GAP=3:
   - exactly 3 rd_en-free cycles after addresses 3 and 7, none after address 11.
   - total 14 data_en cycles; frame_done as before.
3. hold=1 for 4 cycles starting the cycle after rd_addr=4 is issued:
   - pixel 5 still appears on per_img_Y; rd_en stays low for 4 cycles.
   - reads resume at rd_addr=5.
   - output is 1..12, 0, 0 with no gaps in value order, 14 data_en total.
4. frame_go pulsed while busy -> no effect. frame_go in the cycle after frame_done -> the second frame starts at rd_addr=0 and also produces 14 data_en.
5. rst_n=0 for 1 cycle while rd_addr=6:
   - next cycle rd_en, start, data_en, busy and frame_done are 0 and per_img_Y=0; no frame_done follows.
   - a new frame_go then yields a complete 1..12, 0, 0 frame.
6. Default parameters, frame_go -> data_en count = 325122, last rd_addr = 325119, exactly one frame_done.
